clk_pll_drp_reconfig: RTL



---
 rtl/clk_pll_drp_reconfig.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clk_pll_drp_reconfig.sv
// clk_pll_drp_reconfig: holds a PLL in reset while read-modify-writing its DRP divider registers.
// Define DRP_TIMEOUT_EN to abort DRDY/lock waits after TIMEOUT cycles with an err pulse.
module clk_pll_drp_reconfig #(
   parameter int         NUM_CH     = 2,
   parameter int         DIV_MAX    = 128,
   parameter logic [6:0] ADDR_BASE  = 7'h08,
   parameter int         RST_CYCLES = 8,
   parameter int         TIMEOUT    = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [8*NUM_CH-1:0] cfg_div,
   input  logic [NUM_CH-1:0]   cfg_mask,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                locked,
   output logic                pll_rst,
   input  logic                pll_locked,
   output logic                drp_den,
   output logic                drp_dwe,
   output logic [6:0]          drp_daddr,
   output logic [15:0]         drp_di,
   input  logic [15:0]         drp_do,
   input  logic                drp_drdy
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int NC = 2 ** CW;
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [8:0] DMAX = 9'(DIV_MAX);

   if (NUM_CH < 1 || NUM_CH > 7 || TIMEOUT < 1 || RST_CYCLES < 1) begin : g_bad_param
      $error("clk_pll_drp_reconfig: illegal parameter value");
   end

   typedef enum logic [3:0] {
      IDLE, RST_HOLD, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, LOCK_WAIT, DONE
   } state_t;

   state_t          state;
   logic [8*NC-1:0] div_r;
   logic [NC-1:0]   mask_r;
   logic [CW-1:0]   ch;
   logic            reg_sel;
   logic [RW-1:0]   cnt;
   logic [15:0]     rd;
   logic [1:0]      sync;
   logic            bad;
   logic [CW:0]     first;
   logic [CW:0]     nxt;
   logic [7:0]      d;
   logic [15:0]     wr_word;
`ifdef DRP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]   tcnt;
`endif

   // lowest masked channel above 'from'; MSB flags that one was found
   function automatic logic [CW:0] find(input logic [NC-1:0] m, input int from);
      find = '0;
      for (int c = NC - 1; c >= 0; c--)
         if (m[c] && c > from) find = {1'b1, CW'(c)};
   endfunction

   always_comb begin
      bad = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         if (cfg_mask[c] && (cfg_div[8*c +: 8] == 8'd0 || {1'b0, cfg_div[8*c +: 8]} > DMAX)) bad = 1'b1;
      first = find(NC'(cfg_mask), -1);
      nxt = find(mask_r, int'(ch));
      d = div_r[{ch, 3'b000} +: 8];
      // a count of 64 truncates to 6'd0, which the DRP reads as 64
      wr_word = reg_sel ? (rd & 16'hFF3F) | {8'h00, d[0], d == 8'd1, 6'h00}
                        : (rd & 16'hF000) | {4'h0, 6'(d >> 1), 6'(d - (d >> 1))};
   end

   assign cfg_ready = state == IDLE;
   assign busy = state != IDLE;
   assign locked = sync[1] & ~busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         div_r <= '0;
         mask_r <= '0;
         ch <= '0;
         reg_sel <= 1'b0;
         cnt <= '0;
         rd <= '0;
         sync <= '0;
         done <= 1'b0;
         err <= 1'b0;
         pll_rst <= 1'b0;
         drp_den <= 1'b0;
         drp_dwe <= 1'b0;
         drp_daddr <= '0;
         drp_di <= '0;
`ifdef DRP_TIMEOUT_EN
         tcnt <= '0;
`endif
      end else begin
         sync <= {sync[0], pll_locked};
         done <= 1'b0;
         err <= 1'b0;
         drp_den <= 1'b0;
         drp_dwe <= 1'b0;
         case (state)
            IDLE: if (cfg_valid) begin
               if (bad) err <= 1'b1;
               else if (!first[CW]) done <= 1'b1;
               else begin
                  div_r <= (8*NC)'(cfg_div);
                  mask_r <= NC'(cfg_mask);
                  ch <= first[CW-1:0];
                  reg_sel <= 1'b0;
                  cnt <= '0;
                  pll_rst <= 1'b1;
                  state <= RST_HOLD;
               end
            end
            RST_HOLD: begin
               cnt <= cnt + 1'b1;
               if (cnt == RW'(RST_CYCLES - 1)) state <= RD;
            end
            RD: begin
               drp_den <= 1'b1;
               drp_daddr <= ADDR_BASE + 7'({ch, reg_sel});
               state <= RD_WAIT;
            end
            RD_WAIT: if (drp_drdy) begin
               rd <= drp_do;
               state <= WR;
            end
            WR: begin
               drp_den <= 1'b1;
               drp_dwe <= 1'b1;
               drp_di <= wr_word;
               state <= WR_WAIT;
            end
            WR_WAIT: if (drp_drdy) state <= NEXT;
            NEXT: begin
               if (!reg_sel) begin
                  reg_sel <= 1'b1;
                  state <= RD;
               end else if (nxt[CW]) begin
                  ch <= nxt[CW-1:0];
                  reg_sel <= 1'b0;
                  state <= RD;
               end else begin
                  pll_rst <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: state <= LOCK_WAIT;
            LOCK_WAIT: if (sync[1]) begin
               done <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
`ifdef DRP_TIMEOUT_EN
         tcnt <= (state == RD || state == WR || state == RELEASE) ? '0 : tcnt + 1'b1;
         if (tcnt == TW'(TIMEOUT - 1) &&
             (((state == RD_WAIT || state == WR_WAIT) && !drp_drdy) || (state == LOCK_WAIT && !sync[1]))) begin
            err <= 1'b1;
            pll_rst <= 1'b0;
            state <= IDLE;
         end
`endif
      end
   end
endmodule
